psram_access_sequencer: RTL and testbench

// Sequences rv32i core loads/stores onto the 16-bit PSRAM driver. Splits each access into

---
 rtl/psram_access_sequencer.sv | 120 ++++++++++++
 tb/tb_psram_access_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_access_sequencer.sv
// psram_access_sequencer: splits rv32i loads/stores into 16-bit PSRAM transactions,
// stalling the core until the access completes and returning extended load data.
module psram_access_sequencer #(
    parameter int PSRAM_AW = 22
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [1:0]          size,
    input  logic                unsigned_ld,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic                stall,
    output logic [31:0]         rdata,
    output logic                done,
    output logic                err,
    output logic [PSRAM_AW-1:0] p_addr,
    output logic                p_write_en,
    output logic                p_read_en,
    output logic [15:0]         p_data_in,
    output logic                p_wr_hi,
    output logic                p_wr_lo,
    input  logic                p_busy,
    input  logic                p_read_avail,
    input  logic [15:0]         p_data_out
);
    typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE} state_t;
    state_t              r_state;
    logic                r_we, r_uns, r_a0, r_busy_seen, r_err;
    logic                r_p_write_en, r_p_read_en, r_p_wr_hi, r_p_wr_lo;
    logic [1:0]          r_size;
    logic [15:0]         r_whi, r_lo, r_p_data_in;
    logic [PSRAM_AW-1:0] r_p_addr;
    logic [31:0]         r_rdata;
    logic                w_byte, w_word, w_mis, w_exit, w_unused;
    logic [15:0]         w_half;
    logic [31:0]         w_ext;
    assign w_byte   = size == 2'd0;
    assign w_word   = size[1];
    assign w_mis    = (size == 2'd1 && addr[0]) || (w_word && addr[1:0] != 2'b00);
    assign w_exit   = r_we ? (r_busy_seen && !p_busy) : p_read_avail;
    assign w_unused = ^addr[31:PSRAM_AW+1];
    // extension uses the latched access attributes, not the live core inputs
    assign w_half = r_size == 2'd0 ? {8'h00, r_a0 ? p_data_out[15:8] : p_data_out[7:0]} : p_data_out;
    assign w_ext  = r_size == 2'd0 ? {{24{!r_uns && w_half[7]}}, w_half[7:0]}
                                   : {{16{!r_uns && w_half[15]}}, w_half};
    assign stall      = r_state == IDLE ? req : r_state != DONE;
    assign done       = r_state == DONE;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign p_addr     = r_p_addr;
    assign p_write_en = r_p_write_en;
    assign p_read_en  = r_p_read_en;
    assign p_data_in  = r_p_data_in;
    assign p_wr_hi    = r_p_wr_hi;
    assign p_wr_lo    = r_p_wr_lo;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_a0         <= 1'b0;
            r_size       <= 2'd0;
            r_whi        <= '0;
            r_lo         <= '0;
            r_busy_seen  <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_p_addr     <= '0;
            r_p_data_in  <= '0;
            r_p_write_en <= 1'b0;
            r_p_read_en  <= 1'b0;
            r_p_wr_hi    <= 1'b0;
            r_p_wr_lo    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req) begin
                    r_we        <= we;
                    r_size      <= size;
                    r_uns       <= unsigned_ld;
                    r_a0        <= addr[0];
                    r_whi       <= wdata[31:16];
                    r_p_addr    <= addr[PSRAM_AW:1];
                    r_p_data_in <= w_byte ? {2{wdata[7:0]}} : wdata[15:0];
                    r_p_wr_hi   <= we && (!w_byte || addr[0]);
                    r_p_wr_lo   <= we && (!w_byte || !addr[0]);
                    r_err       <= w_mis;
                    r_state     <= w_mis ? DONE : ISSUE_LO;
                end
                ISSUE_LO, ISSUE_HI: if (!p_busy) begin
                    r_p_write_en <= r_we;
                    r_p_read_en  <= !r_we;
                    r_busy_seen  <= 1'b0;
                    r_state      <= r_state == ISSUE_LO ? WAIT_LO : WAIT_HI;
                end
                WAIT_LO, WAIT_HI: begin
                    r_p_write_en <= 1'b0;
                    r_p_read_en  <= 1'b0;
                    r_busy_seen  <= r_busy_seen || p_busy;
                    if (w_exit) begin
                        if (r_state == WAIT_LO && r_size[1]) begin
                            r_lo        <= p_data_out;
                            r_p_addr    <= r_p_addr + PSRAM_AW'(1);
                            r_p_data_in <= r_whi;
                            r_state     <= ISSUE_HI;
                        end else begin
                            r_rdata <= r_state == WAIT_HI ? {p_data_out, r_lo} : w_ext;
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psram_access_sequencer.sv
// tb_psram_access_sequencer: table vectors, random accesses against a byte-level memory
// model, and hand-written busy/reset/stray-pulse sequences for the PSRAM access sequencer.
module tb_psram_access_sequencer;
    localparam int AW = 22;
    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e;
        logic [31:0] rd;
    } vec_t;
    logic clk = 0, reset = 1, req = 0, we = 0, unsigned_ld = 0;
    logic [1:0] size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic stall, done, err, p_write_en, p_read_en, p_wr_hi, p_wr_lo, p_busy, p_read_avail;
    logic [31:0] rdata;
    logic [AW-1:0] p_addr;
    logic [15:0] p_data_in, p_data_out;
    logic ext_busy = 0, ext_avail = 0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    psram_access_sequencer #(.PSRAM_AW(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .unsigned_ld(unsigned_ld),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done), .err(err),
        .p_addr(p_addr), .p_write_en(p_write_en), .p_read_en(p_read_en), .p_data_in(p_data_in),
        .p_wr_hi(p_wr_hi), .p_wr_lo(p_wr_lo), .p_busy(p_busy), .p_read_avail(p_read_avail),
        .p_data_out(p_data_out)
    );

    // PSRAM driver model: busy for 1..3 cycles after an issue pulse, then commits or returns data
    logic m_busy = 0, m_avail = 0, m_wr = 0, m_hi = 0, m_lo = 0;
    int m_cnt = 0;
    logic [AW-1:0] m_a = 0;
    logic [15:0] m_d = 0, m_q = 0;
    logic [15:0] mem [int];
    assign p_busy = m_busy | ext_busy;
    assign p_read_avail = m_avail | ext_avail;
    assign p_data_out = m_q;
    always @(posedge clk) begin : drv
        logic [15:0] v;
        m_avail <= 1'b0;
        if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                v = mem.exists(int'(m_a)) ? mem[int'(m_a)] : 16'h0;
                if (m_wr) begin
                    if (m_hi) v[15:8] = m_d[15:8];
                    if (m_lo) v[7:0] = m_d[7:0];
                    mem[int'(m_a)] = v;
                end else begin
                    m_q <= v;
                    m_avail <= 1'b1;
                end
            end
        end else if (p_write_en || p_read_en) begin
            m_busy <= 1'b1;
            m_cnt  <= $urandom_range(1, 3);
            m_wr   <= p_write_en;
            m_a    <= p_addr;
            m_d    <= p_data_in;
            m_hi   <= p_wr_hi;
            m_lo   <= p_wr_lo;
        end
    end

    // issue log: {p_addr, p_data_in, p_wr_hi, p_wr_lo, p_write_en}
    int mon_n = 0;
    logic [AW+18:0] ilog [1024];
    always @(posedge clk) begin
        if (p_write_en || p_read_en) begin
            ilog[mon_n % 1024] <= {p_addr, p_data_in, p_wr_hi, p_wr_lo, p_write_en};
            mon_n <= mon_n + 1;
        end
    end

    // reference: byte-addressed memory, aligned accesses of 1/2/4 bytes, little endian
    logic [7:0] sh [int];
    task automatic ref_access(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                              input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        int k = int'(a[AW:0]);
        e = (int'(a[1:0]) % n) != 0;
        rd = 0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (w) sh[k + i] = wd[8*i +: 8];
                else rd[8*i +: 8] = sh.exists(k + i) ? sh[k + i] : 8'h00;
            end
            if (!w && !u && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_access(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                              input logic [31:0] wd, output logic gd, output logic ge, output logic [31:0] gr,
                              output int cyc, output logic sok, output int n0);
        @(negedge clk);
        n0 = mon_n;
        req = 1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = wd;
        sok = 1'b1;
        cyc = 0;
        #1;
        while (!done && cyc < 200) begin
            if (!stall) sok = 1'b0;
            @(negedge clk);
            #1;
            cyc++;
        end
        gd = done; ge = err; gr = rdata;
        if (done && stall) sok = 1'b0;
        req = 0;
    endtask

    task automatic access_check(input string tag, input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic ge, output logic [31:0] gr);
        logic gd, sok, ee;
        logic [31:0] er;
        int cyc, n0, ni;
        logic [AW+18:0] l;
        logic [AW-1:0] ea;
        run_access(w, sz, u, a, wd, gd, ge, gr, cyc, sok, n0);
        ref_access(w, sz, u, a, wd, ee, er);
        ni = ee ? 0 : (sz[1] ? 2 : 1);
        chk({tag, " done"}, gd, 1);
        chk({tag, " err"}, ge, ee);
        chk({tag, " stall"}, sok, 1);
        chk({tag, " issues"}, mon_n - n0, ni);
        if (!w && !ee) chk({tag, " rdata"}, gr, er);
        if (ee) chk({tag, " err latency"}, cyc, 1);
        else chk({tag, " latency"}, cyc >= (ni == 2 ? 5 : 3), 1);
        for (int j = 0; j < ni && mon_n - n0 == ni; j++) begin
            l = ilog[(n0 + j) % 1024];
            ea = a[AW:1] + AW'(j);
            chk({tag, " p_addr"}, l[AW+18:19], ea);
            chk({tag, " dir"}, l[0], w);
            if (w) begin
                chk({tag, " p_data_in"}, l[18:3], sz == 2'd0 ? {wd[7:0], wd[7:0]} : (j == 1 ? wd[31:16] : wd[15:0]));
                chk({tag, " p_wr_hi"}, l[2], sz == 2'd0 ? a[0] : 1'b1);
                chk({tag, " p_wr_lo"}, l[1], sz == 2'd0 ? !a[0] : 1'b1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        logic ge, ee;
        logic [31:0] gr, er;
        int k, seen;
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 32'h102, 32'h000080AA, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        1'b0, 32'hFFFFFF80};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        1'b0, 32'h00000080};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h5,   32'h12,       1'b0, 32'h0};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h4,   32'h0,        1'b0, 32'h00001200};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h4,   32'h0,        1'b0, 32'h0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        1'b1, 32'h0};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h7,   32'h5555,     1'b1, 32'h0};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        1'b0, 32'hFFFF80AA};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        1'b0, 32'h80AABEEF};
        tbl[12] = '{1'b1, 2'd0, 1'b0, 32'h4,   32'hFFFFFF34, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 32'h4,   32'h0,        1'b0, 32'h00001234};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        1'b0, 32'hFFFFFFBE};
        tbl[15] = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        1'b0, 32'h000080AA};
        #12;
        chk("reset rdata", rdata, 0);
        chk("reset ctrl", {stall, done, err, p_write_en, p_read_en, p_wr_hi, p_wr_lo}, 0);
        chk("reset p_addr", p_addr, 0);
        chk("reset p_data_in", p_data_in, 0);
        @(negedge clk);
        reset = 0;
        // stray read_avail while idle must not start or finish anything
        @(negedge clk);
        k = mon_n;
        ext_avail = 1;
        @(negedge clk);
        ext_avail = 0;
        seen = 0;
        repeat (3) begin
            #1;
            if (done || stall) seen++;
            @(negedge clk);
        end
        chk("stray avail ignored", seen, 0);
        chk("stray avail no issue", mon_n - k, 0);
        for (int i = 0; i < 16; i++) begin
            access_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, ge, gr);
            chk($sformatf("vec%0d table err", i), ge, tbl[i].e);
            if (!tbl[i].w && !tbl[i].e) chk($sformatf("vec%0d table rdata", i), gr, tbl[i].rd);
        end
        // req dropped after the first cycle: access still completes
        @(negedge clk);
        req = 1; we = 0; size = 2'd0; unsigned_ld = 0; addr = 32'h103;
        @(negedge clk);
        req = 0;
        seen = 0;
        gr = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            @(negedge clk);
            #1;
            if (done) begin
                seen = 1;
                gr = rdata;
            end
        end
        ref_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, ee, er);
        chk("req drop done", seen, 1);
        chk("req drop rdata", gr, er);
        for (int i = 0; i < 300; i++) begin
            access_check($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), ($urandom & 32'hFF80_0000) | 32'($urandom_range(0, 31)),
                         $urandom, ge, gr);
        end
        // driver busy for 10 cycles, then reset while the high half is in flight
        ext_busy = 1;
        @(negedge clk);
        k = mon_n;
        req = 1; we = 0; size = 2'd2; unsigned_ld = 0; addr = 32'h100;
        seen = 0;
        repeat (10) begin
            #1;
            if (!stall || p_read_en) seen++;
            @(negedge clk);
        end
        chk("busy hold issues", mon_n - k, 0);
        chk("busy hold stall", seen, 0);
        ext_busy = 0;
        seen = 0;
        for (int c = 0; c < 100 && seen < 2; c++) begin
            @(negedge clk);
            #1;
            if (p_read_en) seen++;
        end
        chk("reached WAIT_HI", seen, 2);
        reset = 1;
        req = 0;
        #1;
        chk("abort ctrl", {stall, done, err, p_write_en, p_read_en, p_wr_hi, p_wr_lo}, 0);
        chk("abort rdata", rdata, 0);
        chk("abort p_addr", p_addr, 0);
        chk("abort p_data_in", p_data_in, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (stall || done) seen++;
        end
        chk("post reset idle", seen, 0);
        access_check("post reset", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, ge, gr);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
